// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit outcome counters.
// Zero-latency lookup beside the fetch PC; trained by branch resolution in ID.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 8,
  parameter int MODE    = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_next_pc_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_i,
  input  logic [ADDR_W-1:0] upd_pred_tgt_i,
  input  logic              flush_i,
  output logic              mispredict_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int HI_W  = IDX_W + TAG_W + 2;

  logic              valid_reg  [ENTRIES];
  logic [TAG_W-1:0]  tag_reg    [ENTRIES];
  logic [ADDR_W-1:0] target_reg [ENTRIES];
  logic [1:0]        ctr_reg    [ENTRIES];

  logic              mispredict_reg;
  logic [CNT_W-1:0]  branch_cnt_reg;
  logic [CNT_W-1:0]  mispred_cnt_reg;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              mispredict;
  logic              arr_we;
  logic [1:0]        upd_ctr_next;
  logic [ENTRIES-1:0] entry_sel;

  assign lk_idx  = pc_i[IDX_W+1:2];
  assign lk_tag  = pc_i[HI_W-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[HI_W-1:IDX_W+2];

  // Bits outside the index/tag fields take no part in prediction.
  logic unused_lo;
  assign unused_lo = ^{pc_i[1:0], upd_pc_i[1:0]};
  generate
    if (HI_W < ADDR_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{pc_i[ADDR_W-1:HI_W], upd_pc_i[ADDR_W-1:HI_W]};
    end
  endgenerate

  assign lk_hit         = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign pred_taken_o   = (MODE != 0) && lk_hit && ctr_reg[lk_idx][1];
  assign pred_next_pc_o = pred_taken_o ? target_reg[lk_idx] : pc_i + ADDR_W'(4);

  assign upd_hit    = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign mispredict = (upd_taken_i != upd_pred_i) ||
                      (upd_taken_i && (upd_pred_tgt_i != upd_target_i));
  // A concurrent flush wins over training; static mode never trains.
  assign arr_we     = upd_valid_i && !flush_i && (MODE != 0);

  always_comb begin
    upd_ctr_next = ctr_reg[upd_idx];
    if (MODE == 1) begin
      upd_ctr_next = {upd_taken_i, 1'b0};
    end else if (upd_taken_i && ctr_reg[upd_idx] != 2'b11) begin
      upd_ctr_next = ctr_reg[upd_idx] + 2'b01;
    end else if (!upd_taken_i && ctr_reg[upd_idx] != 2'b00) begin
      upd_ctr_next = ctr_reg[upd_idx] - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign entry_sel[gi] = arr_we && (upd_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush_i) begin
          valid_reg[i] <= 1'b0;
        end else if (entry_sel[i]) begin
          if (upd_hit) begin
            ctr_reg[i] <= upd_ctr_next;
            if (upd_taken_i) target_reg[i] <= upd_target_i;
          end else if (upd_taken_i) begin
            valid_reg[i]  <= 1'b1;
            tag_reg[i]    <= upd_tag;
            target_reg[i] <= upd_target_i;
            ctr_reg[i]    <= 2'b10;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mispredict_reg  <= 1'b0;
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      mispredict_reg <= upd_valid_i && mispredict;
      if (upd_valid_i && branch_cnt_reg != '1)
        branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
      if (upd_valid_i && mispredict && mispred_cnt_reg != '1)
        mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
    end
  end

  assign mispredict_o  = mispredict_reg;
  assign branch_cnt_o  = branch_cnt_reg;
  assign mispred_cnt_o = mispred_cnt_reg;

endmodule
